// File: rtl/vc_credit_tx_pkg.sv
// Shared configuration for the VC credit transmitter: packet type and credit-width helper.
package vc_credit_tx_pkg;

    localparam int PKT_W = 32;

    typedef struct packed {
        logic [3:0]  src;
        logic [27:0] payload;
    } packet_t;

    // Counter must hold the full range 0..DEPTH inclusive.
    function automatic int CREDIT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vc_credit_tx_counter.sv
// Per-VC credit counter: tracks free downstream slots, saturates at DEPTH.
// Overflow detection is built only when VC_CREDIT_ERR_EN is defined.
module vc_credit_counter
    import vc_credit_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_dec,
    input  logic i_inc,
    output logic o_avail,
    output logic o_ovf
);

    localparam int W = CREDIT_W(DEPTH);
    localparam logic [W-1:0] FULL = W'(DEPTH);

    logic        [W-1:0] r_credit_p1;
    logic                r_avail_p1;
    logic        [W:0]   w_sum;
    logic        [W-1:0] w_next;

    function automatic logic [W-1:0] sat_credit(input logic [W:0] v);
        return (v > (W+1)'(DEPTH)) ? FULL : v[W-1:0];
    endfunction

    // Decrement is gated upstream by o_avail, so the sum never goes below zero.
    assign w_sum  = {1'b0, r_credit_p1} + (W+1)'(i_inc) - (W+1)'(i_dec);
    assign w_next = sat_credit(w_sum);

    // ---- stage p1: credit state and registered availability ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit_p1 <= FULL;
            r_avail_p1  <= 1'b1;
        end else begin
            r_credit_p1 <= w_next;
            r_avail_p1  <= (w_next != '0);
        end
    end

    assign o_avail = r_avail_p1;

`ifdef VC_CREDIT_ERR_EN
    assign o_ovf = i_inc & ~i_dec & (r_credit_p1 == FULL);
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/vc_credit_tx.sv
// Credit-based VC link transmitter: onehot check, accept gate, output register.
// Optional sticky error detection enabled by the VC_CREDIT_ERR_EN macro.
module vc_credit_tx
    import vc_credit_tx_pkg::*;
#(
    parameter int M     = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  packet_t       i_data,
    input  logic          i_data_val,
    input  logic [0:M-1]  i_vc,
    output logic          o_en,
    output packet_t       o_data,
    output logic [0:M-1]  o_data_val,
    input  logic [0:M-1]  i_credit,
    output logic [0:M-1]  o_vc_avail,
    output logic          o_err
);

    logic          w_onehot;
    logic          w_accept;
    logic [0:M-1]  w_avail;
    logic [0:M-1]  w_ovf;
    packet_t       r_data_p1;
    logic [0:M-1]  r_vld_p1;

    assign w_onehot = (i_vc != '0) && ((i_vc & (i_vc - M'(1))) == '0);
    assign o_en     = w_onehot && |(i_vc & w_avail);
    assign w_accept = i_data_val && o_en;

    for (genvar g = 0; g < M; g++) begin : g_vc
        vc_credit_counter #(
            .DEPTH (DEPTH)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .i_dec   (w_accept & i_vc[g]),
            .i_inc   (i_credit[g]),
            .o_avail (w_avail[g]),
            .o_ovf   (w_ovf[g])
        );
    end

    // ---- stage p1: link output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_p1 <= '0;
            r_vld_p1  <= '0;
        end else begin
            r_vld_p1 <= w_accept ? i_vc : '0;
            if (w_accept) begin
                r_data_p1 <= i_data;
            end
        end
    end

    assign o_data     = r_data_p1;
    assign o_data_val = r_vld_p1;
    assign o_vc_avail = w_avail;

`ifdef VC_CREDIT_ERR_EN
    logic r_err_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_p1 <= 1'b0;
        end else begin
            r_err_p1 <= r_err_p1 | (i_data_val & ~w_onehot) | (|w_ovf);
        end
    end

    assign o_err = r_err_p1;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = |w_ovf;
    assign o_err        = 1'b0;
`endif

endmodule
